// File: rtl/prog_counter_pkg.sv
// Shared constants and direction encoding for the programmable flex counter.
package prog_counter_pkg;

    localparam int DEF_CNT_BITS = 4;
    localparam int DEF_PRESCALE = 1;

    typedef enum logic {
        COUNT_DOWN = 1'b0,
        COUNT_UP   = 1'b1
    } count_dir_e;

endpackage

// File: rtl/flex_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a one-cycle step strobe.
module flex_prescaler
    import prog_counter_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear_or_load,
    input  logic count_enable,
    output logic step
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    // clear/load suppress the strobe so they always win over a step
    assign step = count_enable && !clear_or_load && (pcnt == LAST);

    always_ff @(posedge clk) begin
        if (!n_rst)
            pcnt <= '0;
        else if (clear_or_load)
            pcnt <= '0;
        else if (count_enable)
            pcnt <= step ? '0 : pcnt + PW'(1);
    end

endmodule

// File: rtl/prog_flex_counter.sv
// Up/down counter with runtime terminal value, prescaled stepping and a sticky done flag.
module prog_flex_counter
    import prog_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = DEF_CNT_BITS,
    parameter int PRESCALE     = DEF_PRESCALE
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    count_up,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    done_flag
);

    localparam int N = NUM_CNT_BITS;

    logic         step;
    logic         rv_zero;
    logic [N-1:0] terminal;
    logic [N-1:0] count_next;
    logic         flag_next;
    logic         done_next;

    flex_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear_or_load(clear | load),
        .count_enable (count_enable),
        .step         (step)
    );

    always_comb begin
        rv_zero    = (rollover_val == '0);
        terminal   = (count_up == COUNT_UP) ? rollover_val : N'(1);
        count_next = count_out;
        done_next  = done_flag;
        if (clear) begin
            count_next = '0;
            done_next  = 1'b0;
        end else if (load) begin
            count_next = load_val;
        end else if (step) begin
            // a zero terminal value parks the counter at 0 and never wraps
            if (rv_zero)
                count_next = '0;
            else if (count_up == COUNT_UP)
                count_next = (count_out == rollover_val) ? N'(1) : count_out + N'(1);
            else
                count_next = (count_out <= N'(1)) ? rollover_val : count_out - N'(1);
            if (!rv_zero && count_out == terminal)
                done_next = 1'b1;
        end
        // flag looks at the next count so it lines up with count_out
        flag_next = !rv_zero && (count_next == terminal);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            done_flag     <= 1'b0;
        end else begin
            count_out     <= count_next;
            rollover_flag <= flag_next;
            done_flag     <= done_next;
        end
    end

endmodule

// File: tb/tb_prog_flex_counter.sv
// Directed checks of prog_flex_counter with PRESCALE=1 and PRESCALE=3 instances.
module tb_prog_flex_counter;

    logic       clk = 1'b0;
    logic       n_rst, clear, count_enable, count_up, load;
    logic [3:0] load_val, rollover_val;
    logic [3:0] cnt1, cnt3;
    logic       flg1, flg3, dn1, dn3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prog_flex_counter #(.NUM_CNT_BITS(4), .PRESCALE(1)) u_p1 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable),
        .count_up(count_up), .load(load), .load_val(load_val),
        .rollover_val(rollover_val), .count_out(cnt1),
        .rollover_flag(flg1), .done_flag(dn1)
    );

    prog_flex_counter #(.NUM_CNT_BITS(4), .PRESCALE(3)) u_p3 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable),
        .count_up(count_up), .load(load), .load_val(load_val),
        .rollover_val(rollover_val), .count_out(cnt3),
        .rollover_flag(flg3), .done_flag(dn3)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_p1(input string tag, input int c, input int f, input int d);
        tick();
        chk({tag, ".cnt"},  int'(cnt1), c);
        chk({tag, ".flag"}, int'(flg1), f);
        chk({tag, ".done"}, int'(dn1),  d);
    endtask

    task automatic tick_p3(input string tag, input int c, input int f, input int d);
        tick();
        chk({tag, ".cnt"},  int'(cnt3), c);
        chk({tag, ".flag"}, int'(flg3), f);
        chk({tag, ".done"}, int'(dn3),  d);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0; clear = 1'b0; count_enable = 1'b0; count_up = 1'b1;
        load = 1'b0; load_val = 4'd0; rollover_val = 4'd5;

        // reset state
        do_reset();
        chk("rst.cnt1", int'(cnt1), 0);
        chk("rst.flg1", int'(flg1), 0);
        chk("rst.dn1",  int'(dn1),  0);
        chk("rst.cnt3", int'(cnt3), 0);
        chk("rst.flg3", int'(flg3), 0);
        chk("rst.dn3",  int'(dn3),  0);

        // up count to 5, wrap to 1, done after first wrap
        count_enable = 1'b1;
        tick_p1("up5_1", 1, 0, 0);
        tick_p1("up5_2", 2, 0, 0);
        tick_p1("up5_3", 3, 0, 0);
        tick_p1("up5_4", 4, 0, 0);
        tick_p1("up5_5", 5, 1, 0);
        tick_p1("up5_6", 1, 0, 1);
        tick_p1("up5_7", 2, 0, 1);
        tick_p1("up5_8", 3, 0, 1);
        tick_p1("up5_9", 4, 0, 1);
        tick_p1("up5_10", 5, 1, 1);
        tick_p1("up5_11", 1, 0, 1);
        tick_p1("up5_12", 2, 0, 1);

        // prescale by 3, rollover 2, freeze while disabled
        count_enable = 1'b0;
        do_reset();
        rollover_val = 4'd2; count_enable = 1'b1;
        tick_p3("ps_1", 0, 0, 0);
        tick_p3("ps_2", 0, 0, 0);
        tick_p3("ps_3", 1, 0, 0);
        tick_p3("ps_4", 1, 0, 0);
        tick_p3("ps_5", 1, 0, 0);
        tick_p3("ps_6", 2, 1, 0);
        tick_p3("ps_7", 2, 1, 0);
        count_enable = 1'b0;
        tick_p3("ps_hold1", 2, 1, 0);
        tick_p3("ps_hold2", 2, 1, 0);
        tick_p3("ps_hold3", 2, 1, 0);
        tick_p3("ps_hold4", 2, 1, 0);
        count_enable = 1'b1;
        tick_p3("ps_8", 2, 1, 0);
        tick_p3("ps_9", 1, 0, 1);

        // down mode from 0 with rollover 4
        count_enable = 1'b0;
        do_reset();
        rollover_val = 4'd4; count_up = 1'b0; count_enable = 1'b1;
        tick_p1("dn_1", 4, 0, 0);
        tick_p1("dn_2", 3, 0, 0);
        tick_p1("dn_3", 2, 0, 0);
        tick_p1("dn_4", 1, 1, 0);
        tick_p1("dn_5", 4, 0, 1);

        // load above rollover, wrap through 0
        count_enable = 1'b0;
        do_reset();
        rollover_val = 4'd3; count_up = 1'b1; count_enable = 1'b1;
        load = 1'b1; load_val = 4'd14;
        tick_p1("ld_14", 14, 0, 0);
        load = 1'b0;
        tick_p1("ld_15", 15, 0, 0);
        tick_p1("ld_0", 0, 0, 0);
        tick_p1("ld_1", 1, 0, 0);
        tick_p1("ld_2", 2, 0, 0);
        tick_p1("ld_3", 3, 1, 0);
        tick_p1("ld_wrap", 1, 0, 1);

        // clear together with load: clear wins
        clear = 1'b1; load = 1'b1; load_val = 4'd7;
        tick_p1("clr_ld", 0, 0, 0);
        clear = 1'b0; load = 1'b0;

        // reset mid-count, resume from 0
        rollover_val = 4'd5;
        tick_p1("mid_1", 1, 0, 0);
        tick_p1("mid_2", 2, 0, 0);
        tick_p1("mid_3", 3, 0, 0);
        n_rst = 1'b0;
        tick_p1("mid_rst", 0, 0, 0);
        n_rst = 1'b1;
        tick_p1("mid_resume", 1, 0, 0);

        // flag follows rollover_val / count_up with count held
        count_enable = 1'b0; rollover_val = 4'd1;
        tick_p1("rv_chg", 1, 1, 0);
        rollover_val = 4'd5; count_up = 1'b0;
        tick_p1("dir_chg", 1, 1, 0);
        count_up = 1'b1;
        tick_p1("dir_back", 1, 0, 0);

        // zero rollover value holds at 0
        do_reset();
        rollover_val = 4'd0; count_enable = 1'b1;
        for (int i = 0; i < 10; i++)
            tick_p1($sformatf("rv0_%0d", i), 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
